uart_slave: RTL and testbench

- Memory-mapped UART peripheral that sits on one slave port of the shared bus, alongside the ROM (slot 0) and GPIO (slot 4) slaves; intended for slot 3.
- Accepts reads and writes from the bus, serialises TX bytes onto the UartTX pin and deserialises UartRX.
- Raises level interrupts toward the CPU IRQ vector.

---
 rtl/uart_slave_pkg.sv | 58 +++++
 rtl/uart_rx.sv | 116 +++++++++++
 rtl/uart_tx.sv | 104 ++++++++++
 rtl/uart_slave.sv | 193 +++++++++++++++++++
 tb/tb_uart_slave.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_slave_pkg.sv
// uart_slave_pkg: constants and helpers shared by the UART slave and its
// serial sub-modules.
//   - word-address decode values for the two registers (only Addr[0] decoded)
//   - STATUS register bit positions
//   - 2-bit state encoding shared by the TX and RX state machines
//   - default clock-cycles-per-bit (115200 baud at 100 MHz)
//   - STATUS packing and flag-update helpers
package uart_slave_pkg;

  localparam int WORD_ADDR_BUS = 30;
  localparam int WORD_DATA_BUS = 32;

  localparam logic UART_ADDR_STATUS = 1'b0;
  localparam logic UART_ADDR_DATA   = 1'b1;

  localparam int STAT_RX_INTR   = 0;
  localparam int STAT_TX_INTR   = 1;
  localparam int STAT_RX_BUSY   = 2;
  localparam int STAT_TX_BUSY   = 3;
  localparam int STAT_FRAME_ERR = 4;
  localparam int STAT_OVERRUN   = 5;
  localparam int STAT_FIFO_FULL = 6;

  localparam logic [15:0] UART_DIV_RATE = 16'd868;

  localparam int UART_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    UART_STATE_IDLE  = 2'd0,
    UART_STATE_START = 2'd1,
    UART_STATE_DATA  = 2'd2,
    UART_STATE_STOP  = 2'd3
  } uartState_e;

  // Sticky flag update: a hardware set in the same cycle as a software
  // clear wins.
  function automatic logic nextFlag(input logic cur, input logic set,
                                    input logic clr);
    return set | (cur & ~clr);
  endfunction

  function automatic logic [WORD_DATA_BUS-1:0] packStatus(
      input logic rxIntr, input logic txIntr, input logic rxBusy,
      input logic txBusy, input logic frameErr, input logic overrun,
      input logic fifoFull);
    logic [WORD_DATA_BUS-1:0] s;
    s                 = '0;
    s[STAT_RX_INTR]   = rxIntr;
    s[STAT_TX_INTR]   = txIntr;
    s[STAT_RX_BUSY]   = rxBusy;
    s[STAT_TX_BUSY]   = txBusy;
    s[STAT_FRAME_ERR] = frameErr;
    s[STAT_OVERRUN]   = overrun;
    s[STAT_FIFO_FULL] = fifoFull;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserialiser with input synchroniser and its own baud counter.
// Ports:
//   clk, reset_   system clock, synchronous active-high reset
//   uartRx        asynchronous serial input
//   busy          frame in progress
//   done          single-cycle strobe at the middle of the stop bit
//   rxByte        assembled byte, valid while done is high
//   stopBit       sampled stop-bit level, valid while done is high
module uart_rx
  import uart_slave_pkg::*;
#(
  parameter logic [15:0] DIV_RATE = UART_DIV_RATE,
  parameter int          DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              uartRx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rxByte,
  output logic              stopBit
);

  localparam int CNT_W = $clog2(DIV_RATE);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV_RATE - 16'd1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((DIV_RATE / 16'd2) - 16'd1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  uartState_e        state;
  logic [CNT_W-1:0]  baudCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic              syncMeta;
  logic              rxSync;
  logic              rxPrev;
  logic              baudEnd;

  assign baudEnd = (baudCnt == BAUD_LAST);
  assign busy    = (state != UART_STATE_IDLE);
  assign done    = (state == UART_STATE_STOP) && baudEnd;
  assign rxByte  = shiftReg;
  assign stopBit = rxSync;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection;
  // all reset to the idle (high) line level so reset never looks like a
  // start bit.
  always_ff @(posedge clk) begin
    if (reset_) begin
      syncMeta <= 1'b1;
      rxSync   <= 1'b1;
      rxPrev   <= 1'b1;
    end else begin
      syncMeta <= uartRx;
      rxSync   <= syncMeta;
      rxPrev   <= rxSync;
    end
  end

  // START only waits half a bit, re-checks the line and then restarts the
  // counter, so every later sample lands in the middle of its bit.
  always_ff @(posedge clk) begin
    if (reset_) begin
      state   <= UART_STATE_IDLE;
      baudCnt <= '0;
      bitCnt  <= '0;
    end else begin
      case (state)
        UART_STATE_IDLE: begin
          if (rxPrev && !rxSync) begin
            state   <= UART_STATE_START;
            baudCnt <= '0;
          end
        end
        UART_STATE_START: begin
          if (baudCnt == HALF_LAST) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            state   <= rxSync ? UART_STATE_IDLE : UART_STATE_DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        UART_STATE_DATA: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (bitCnt == BIT_LAST) begin
              state <= UART_STATE_STOP;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        UART_STATE_STOP: begin
          if (baudEnd) begin
            state   <= UART_STATE_IDLE;
            baudCnt <= '0;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: state <= UART_STATE_IDLE;
      endcase
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if ((state == UART_STATE_DATA) && baudEnd) begin
      shiftReg <= {rxSync, shiftReg[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser with its own baud counter.
// Ports:
//   clk, reset_   system clock, synchronous active-high reset
//   start         load request; honoured only while idle
//   txByte        byte to send (LSB first)
//   uartTx        registered serial output, idle high
//   busy          frame in progress
//   done          single-cycle strobe on the last cycle of the stop bit
module uart_tx
  import uart_slave_pkg::*;
#(
  parameter logic [15:0] DIV_RATE = UART_DIV_RATE,
  parameter int          DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic [DATA_W-1:0] txByte,
  output logic              uartTx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DIV_RATE);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV_RATE - 16'd1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  uartState_e        state;
  logic [CNT_W-1:0]  baudCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic              baudEnd;

  assign baudEnd = (baudCnt == BAUD_LAST);
  assign busy    = (state != UART_STATE_IDLE);
  assign done    = (state == UART_STATE_STOP) && baudEnd;

  // The output bit is registered alongside the state so the line changes on
  // the same edge as the state transition; while in DATA the next bit to
  // drive is shiftReg[1] because the shift happens on that same edge.
  always_ff @(posedge clk) begin
    if (reset_) begin
      state   <= UART_STATE_IDLE;
      baudCnt <= '0;
      bitCnt  <= '0;
      uartTx  <= 1'b1;
    end else begin
      case (state)
        UART_STATE_IDLE: begin
          if (start) begin
            state   <= UART_STATE_START;
            baudCnt <= '0;
            uartTx  <= 1'b0;
          end
        end
        UART_STATE_START: begin
          if (baudEnd) begin
            state   <= UART_STATE_DATA;
            baudCnt <= '0;
            bitCnt  <= '0;
            uartTx  <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        UART_STATE_DATA: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (bitCnt == BIT_LAST) begin
              state  <= UART_STATE_STOP;
              uartTx <= 1'b1;
            end else begin
              bitCnt <= bitCnt + 1'b1;
              uartTx <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        UART_STATE_STOP: begin
          if (baudEnd) begin
            state   <= UART_STATE_IDLE;
            baudCnt <= '0;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: state <= UART_STATE_IDLE;
      endcase
    end
  end

  // Byte is only captured from idle, so a write during a frame cannot
  // disturb the bits still to be sent.
  always_ff @(posedge clk) begin
    if ((state == UART_STATE_IDLE) && start) begin
      shiftReg <= txByte;
    end else if ((state == UART_STATE_DATA) && baudEnd) begin
      shiftReg <= shiftReg >> 1;
    end
  end

endmodule

// File: rtl/uart_slave.sv
// uart_slave: memory-mapped UART peripheral for one slave slot of the bus.
// Registers (word address, Addr[0]):
//   0 STATUS  [0] rx_intr [1] tx_intr [2] rx_busy [3] tx_busy
//             [4] frame_err [5] overrun [6] fifo_full (FIFO build only)
//             write 0 to bits 0/1/4/5 to clear; bits 2/3 read-only
//   1 DATA    read: received byte; write: byte to transmit
// Ports:
//   clk, reset_       system clock, synchronous active-high reset
//   CS_, As_, RW      active-low select and strobe, 1 = read
//   Addr, WrData      word address and write data
//   RdData, Rdy_      registered response, one cycle after the access
//   IrqRx, IrqTx      level interrupts (rx_intr / tx_intr)
//   UartRX, UartTX    serial input (asynchronous) and output (idle high)
// Build option: define UART_RX_FIFO_EN to place a 4-entry receive FIFO
// behind DATA; rx_intr then means "FIFO not empty".
module uart_slave
  import uart_slave_pkg::*;
#(
  parameter logic [15:0] DIV_RATE = UART_DIV_RATE,
  parameter int          DATA_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     CS_,
  input  logic                     As_,
  input  logic                     RW,
  input  logic [WORD_ADDR_BUS-1:0] Addr,
  input  logic [WORD_DATA_BUS-1:0] WrData,
  output logic [WORD_DATA_BUS-1:0] RdData,
  output logic                     Rdy_,
  output logic                     IrqRx,
  output logic                     IrqTx,
  input  logic                     UartRX,
  output logic                     UartTX
);

  logic                     access;
  logic                     isData;
  logic                     wrStatus;
  logic                     wrData;
  logic                     rdData;
  logic                     txBusy;
  logic                     txDone;
  logic                     rxBusy;
  logic                     rxDone;
  logic [DATA_W-1:0]        rxByte;
  logic                     rxStopBit;
  logic                     rxIntr;
  logic                     txIntr;
  logic                     frameErr;
  logic                     overrun;
  logic                     overrunSet;
  logic                     fifoFull;
  logic [DATA_W-1:0]        dataRead;
  logic [WORD_DATA_BUS-1:0] readMux;
  logic                     unusedBits;

  assign access   = !CS_ && !As_;
  assign isData   = (Addr[0] == UART_ADDR_DATA);
  assign wrStatus = access && !RW && !isData;
  assign wrData   = access && !RW && isData;
  assign rdData   = access && RW && isData;

  assign unusedBits = ^{Addr[WORD_ADDR_BUS-1:1], WrData[WORD_DATA_BUS-1:DATA_W]};

  uart_tx #(
    .DIV_RATE(DIV_RATE),
    .DATA_W  (DATA_W)
  ) txInst (
    .clk   (clk),
    .reset_(reset_),
    .start (wrData),
    .txByte(WrData[DATA_W-1:0]),
    .uartTx(UartTX),
    .busy  (txBusy),
    .done  (txDone)
  );

  uart_rx #(
    .DIV_RATE(DIV_RATE),
    .DATA_W  (DATA_W)
  ) rxInst (
    .clk    (clk),
    .reset_ (reset_),
    .uartRx (UartRX),
    .busy   (rxBusy),
    .done   (rxDone),
    .rxByte (rxByte),
    .stopBit(rxStopBit)
  );

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(UART_FIFO_DEPTH);

  logic [DATA_W-1:0] fifoMem [UART_FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    fifoCnt;
  logic              fifoEmpty;
  logic              push;
  logic              pop;

  assign fifoFull   = (fifoCnt == (PTR_W + 1)'(UART_FIFO_DEPTH));
  assign fifoEmpty  = (fifoCnt == '0);
  assign push       = rxDone && !fifoFull;
  assign pop        = rdData && !fifoEmpty;
  // A byte completing into a full FIFO is dropped and flagged.
  assign overrunSet = rxDone && fifoFull;
  assign rxIntr     = !fifoEmpty;
  assign dataRead   = fifoEmpty ? '0 : fifoMem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset_) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCnt <= fifoCnt + 1'b1;
        2'b01:   fifoCnt <= fifoCnt - 1'b1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= rxByte;
  end
`else
  logic              rxIntrReg;
  logic [DATA_W-1:0] rxData;

  assign fifoFull   = 1'b0;
  // The new byte always overwrites; overrun records that the old one was
  // never acknowledged.
  assign overrunSet = rxDone && rxIntrReg;
  assign rxIntr     = rxIntrReg;
  assign dataRead   = rxData;

  always_ff @(posedge clk) begin
    if (reset_) begin
      rxIntrReg <= 1'b0;
    end else begin
      rxIntrReg <= nextFlag(rxIntrReg, rxDone, wrStatus && !WrData[STAT_RX_INTR]);
    end
  end

  always_ff @(posedge clk) begin
    if (rxDone) rxData <= rxByte;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_) begin
      txIntr   <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      txIntr   <= nextFlag(txIntr, txDone, wrStatus && !WrData[STAT_TX_INTR]);
      frameErr <= nextFlag(frameErr, rxDone && !rxStopBit,
                           wrStatus && !WrData[STAT_FRAME_ERR]);
      overrun  <= nextFlag(overrun, overrunSet, wrStatus && !WrData[STAT_OVERRUN]);
    end
  end

  always_comb begin
    readMux = '0;
    if (isData) begin
      readMux = WORD_DATA_BUS'(dataRead);
    end else begin
      readMux = packStatus(rxIntr, txIntr, rxBusy, txBusy, frameErr, overrun,
                           fifoFull);
    end
  end

  // Bus response: every valid access is acknowledged on the following
  // cycle; writes acknowledge with zero data.
  always_ff @(posedge clk) begin
    if (reset_) begin
      Rdy_   <= 1'b1;
      RdData <= '0;
    end else begin
      Rdy_   <= !access;
      RdData <= (access && RW) ? readMux : '0;
    end
  end

  assign IrqRx = rxIntr;
  assign IrqTx = txIntr;

endmodule

// File: tb/tb_uart_slave.sv
// Testbench for uart_slave at 4 clock cycles per bit. Bus responses are
// checked by a monitor against a queue of expected responses filled when
// each access is issued; serial line and interrupt levels are checked
// directly by the stimulus process.
module tb_uart_slave;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_DATA   = 1'b1;

  logic        clk = 1'b0;
  logic        reset_;
  logic        CS_;
  logic        As_;
  logic        RW;
  logic [29:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Rdy_;
  logic        IrqRx;
  logic        IrqTx;
  logic        UartRX;
  logic        UartTX;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } resp_t;
  resp_t expQ[$];

  uart_slave #(
    .DIV_RATE(16'd4),
    .DATA_W  (8)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .CS_   (CS_),
    .As_   (As_),
    .RW    (RW),
    .Addr  (Addr),
    .WrData(WrData),
    .RdData(RdData),
    .Rdy_  (Rdy_),
    .IrqRx (IrqRx),
    .IrqTx (IrqTx),
    .UartRX(UartRX),
    .UartTX(UartTX)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every Rdy_ low must match the oldest outstanding
  // access, on exactly the cycle after it was issued.
  always @(negedge clk) begin
    if (!Rdy_) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedRdy: Rdy_ low with no access pending, RdData=0x%0h (cycle %0d)",
                 RdData, cyc);
      end else begin
        resp_t e;
        e = expQ.pop_front();
        check("rdyCycle", cyc, e.cycle);
        check("rdData", RdData, e.data);
      end
    end else begin
      check("rdDataIdle", RdData, 32'h0);
    end
  end

  task automatic busIdle();
    CS_    = 1'b1;
    As_    = 1'b1;
    RW     = 1'b1;
    Addr   = '0;
    WrData = '0;
  endtask

  // Drives one access for the coming edge and records its expected response.
  task automatic busDrive(input logic rw, input logic a, input logic [31:0] wd,
                          input logic [31:0] expRd);
    resp_t e;
    CS_    = 1'b0;
    As_    = 1'b0;
    RW     = rw;
    Addr   = {29'b0, a};
    WrData = wd;
    e.data  = expRd;
    e.cycle = cyc + 1;
    expQ.push_back(e);
  endtask

  task automatic busRead(input logic a, input logic [31:0] expRd);
    busDrive(1'b1, a, 32'h0, expRd);
    @(negedge clk);
    busIdle();
  endtask

  task automatic busWrite(input logic a, input logic [31:0] wd);
    busDrive(1'b0, a, wd, 32'h0);
    @(negedge clk);
    busIdle();
  endtask

  // Sends one 8N1 frame, 4 cycles per bit; returns on the negedge just
  // before the edge at which the receiver samples mid-stop.
  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      UartRX = f[k];
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] txFrame;

    reset_ = 1'b1;
    UartRX = 1'b1;
    busIdle();
    repeat (3) @(negedge clk);
    check("rstUartTX", UartTX, 1'b1);
    check("rstRdy", Rdy_, 1'b1);
    check("rstRdData", RdData, 32'h0);
    check("rstIrqRx", IrqRx, 1'b0);
    check("rstIrqTx", IrqTx, 1'b0);
    reset_ = 1'b0;
    @(negedge clk);
    busRead(ADDR_STATUS, 32'h0);

    // Transmit 0x55; a second write mid-frame must be dropped.
    txFrame = {1'b1, 8'h55, 1'b0};
    busWrite(ADDR_DATA, 32'h55);
    for (int i = 1; i <= 40; i++) begin
      check("txLine", UartTX, txFrame[(i - 1) / 4]);
      if (i == 10) busDrive(1'b1, ADDR_STATUS, 32'h0, 32'h08);
      else if (i == 20) busDrive(1'b0, ADDR_DATA, 32'hAA, 32'h0);
      else busIdle();
      @(negedge clk);
    end
    busIdle();
    check("txIrqAfterStop", IrqTx, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("txLineIdleAfter", UartTX, 1'b1);
      @(negedge clk);
    end
    busRead(ADDR_STATUS, 32'h02);
    busWrite(ADDR_STATUS, 32'h0);
    check("txIrqCleared", IrqTx, 1'b0);

`ifdef UART_RX_FIFO_EN
    sendRx(8'hA3, 1'b1);
    @(negedge clk);
    check("rxIrqA3", IrqRx, 1'b1);
    busRead(ADDR_STATUS, 32'h01);
    busRead(ADDR_DATA, 32'hA3);
    check("rxIrqDrained", IrqRx, 1'b0);
    busRead(ADDR_DATA, 32'h0);
    repeat (4) @(negedge clk);

    for (int b = 1; b <= 5; b++) begin
      sendRx(8'(b), 1'b1);
      repeat (4) @(negedge clk);
    end
    busRead(ADDR_STATUS, 32'h61);
    busWrite(ADDR_STATUS, 32'h0);
    busRead(ADDR_STATUS, 32'h41);
    for (int b = 1; b <= 4; b++) busRead(ADDR_DATA, 32'(b));
    busRead(ADDR_DATA, 32'h0);
    busRead(ADDR_STATUS, 32'h0);
`else
    // Receive 0xA3.
    sendRx(8'hA3, 1'b1);
    @(negedge clk);
    check("rxIrqA3", IrqRx, 1'b1);
    busRead(ADDR_DATA, 32'hA3);
    busRead(ADDR_STATUS, 32'h01);
    busWrite(ADDR_STATUS, 32'h0);
    check("rxIrqCleared", IrqRx, 1'b0);
    repeat (4) @(negedge clk);

    // One-cycle start glitch must be ignored.
    UartRX = 1'b0;
    @(negedge clk);
    UartRX = 1'b1;
    repeat (20) @(negedge clk);
    busRead(ADDR_STATUS, 32'h0);
    check("glitchIrqRx", IrqRx, 1'b0);

    // Stop bit low.
    sendRx(8'h5A, 1'b0);
    UartRX = 1'b1;
    repeat (4) @(negedge clk);
    busRead(ADDR_STATUS, 32'h11);
    busRead(ADDR_DATA, 32'h5A);
    busWrite(ADDR_STATUS, 32'h0);
    busRead(ADDR_STATUS, 32'h0);

    // Two bytes without acknowledging the first.
    sendRx(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    sendRx(8'h22, 1'b1);
    @(negedge clk);
    busRead(ADDR_STATUS, 32'h21);
    busRead(ADDR_DATA, 32'h22);
    busWrite(ADDR_STATUS, 32'h0);
    repeat (4) @(negedge clk);

    // Software clear lands on the same edge the byte completes.
    sendRx(8'h3C, 1'b1);
    busWrite(ADDR_STATUS, 32'h0);
    busRead(ADDR_STATUS, 32'h01);
    busRead(ADDR_DATA, 32'h3C);
    busWrite(ADDR_STATUS, 32'h0);
`endif

    // Reset in the middle of a transmit frame.
    repeat (4) @(negedge clk);
    busWrite(ADDR_DATA, 32'h00);
    repeat (5) @(negedge clk);
    check("midFrameLineLow", UartTX, 1'b0);
    reset_ = 1'b1;
    @(negedge clk);
    check("midFrameResetLine", UartTX, 1'b1);
    reset_ = 1'b0;
    repeat (2) @(negedge clk);
    busRead(ADDR_STATUS, 32'h0);
    repeat (45) @(negedge clk);
    check("noIrqAfterAbort", IrqTx, 1'b0);
    check("lineIdleAfterAbort", UartTX, 1'b1);

    repeat (3) @(negedge clk);
    check("pendingResponses", expQ.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
